// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - opcodes, funct3 codes, FSM states and access sizes for the LSU
package load_store_unit_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_BUS   = 2'd1,
    LSU_FAULT = 2'd2,
    LSU_DONE  = 2'd3
  } lsu_state_e;

  // funct3[1:0] of loads and stores encodes the width directly
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } lsu_size_e;

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lane);
    case (size)
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - Wishbone-classic data bus between LSU (master) and memory (slave)
interface load_store_unit_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/inst_immediate_decode.sv
// rtl/inst_immediate_decode.sv - RV32I immediate extraction selected by opcode
module inst_immediate_decode
  import load_store_unit_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] imm
);

  logic [31:0] ins;
  assign ins = instruction;

  // pick the immediate layout for the instruction format; I-type otherwise
  always_comb begin
    imm = {{20{ins[31]}}, ins[31:20]};
    case (ins[6:0])
      OPCODE_STORE:              imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPCODE_BRANCH:             imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPCODE_LUI, OPCODE_AUIPC:  imm = {ins[31:12], 12'h000};
      OPCODE_JAL:                imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:                   imm = {{20{ins[31]}}, ins[31:20]};
    endcase
  end

endmodule

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane selects, store data replication, load extraction/extension
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        zero_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // replicate store data across lanes and right-justify the addressed load lane
  always_comb begin
    shifted   = bus_rdata >> {lane, 3'b000};
    sel       = 4'b1111;
    wdata     = store_data;
    load_data = shifted;
    case (size)
      SIZE_BYTE: begin
        sel       = 4'b0001 << lane;
        wdata     = {4{store_data[7:0]}};
        load_data = zero_ext ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        sel       = 4'b0011 << lane;
        wdata     = {2{store_data[15:0]}};
        load_data = zero_ext ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory stage: one Wishbone transaction per load/store request
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        instruction,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  output logic               busy,
  output logic               done,
  output logic [31:0]        rd_data,
  output logic               misaligned,
  output logic               bus_error,
  load_store_unit_if.master  wb
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  lsu_state_e  state, state_next;
  logic [15:0] cnt;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        we_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, supported, mis_access, timeout_hit;
  lsu_size_e   size;
  logic [31:0] s_imm, ea;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_ldata;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign is_load   = (opcode == OPCODE_LOAD) &&
                     (funct3 == FUNCT3_LB || funct3 == FUNCT3_LH || funct3 == FUNCT3_LW ||
                      funct3 == FUNCT3_LBU || funct3 == FUNCT3_LHU);
  assign is_store  = (opcode == OPCODE_STORE) &&
                     (funct3 == FUNCT3_SB || funct3 == FUNCT3_SH || funct3 == FUNCT3_SW);
  assign supported = is_load || is_store;
  assign size      = lsu_size_e'(funct3[1:0]);

  inst_immediate_decode u_imm (
    .instruction (instruction),
    .imm         (s_imm)
  );

  // loads arrive with the address already summed by the ALU; stores need rs1 + S-imm here
  assign ea          = is_store ? (op_a + s_imm) : alu_out;
  assign mis_access  = is_misaligned(size, ea[1:0]);
  assign timeout_hit = (cnt == TIMEOUT_LIMIT);

  // inputs are stable for the whole request, so live decode also serves load extraction in BUS
  lsu_lane_align u_align (
    .size       (size),
    .zero_ext   (funct3[2]),
    .lane       (ea[1:0]),
    .store_data (op_b),
    .bus_rdata  (wb.wb_dat_i),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .load_data  (lane_ldata)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_next;
  end

  // next-state: err/ack/timeout all leave BUS; fault paths bypass the bus entirely
  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: begin
        if (start) begin
          if (!supported)      state_next = LSU_DONE;
          else if (mis_access) state_next = LSU_FAULT;
          else                 state_next = LSU_BUS;
        end
      end
      LSU_BUS: begin
        if (wb.wb_err_i || wb.wb_ack_i || timeout_hit) state_next = LSU_DONE;
      end
      LSU_FAULT: state_next = LSU_DONE;
      LSU_DONE:  state_next = LSU_IDLE;
      default:   state_next = LSU_IDLE;
    endcase
  end

  // bus request registers, timeout counter, result and fault flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      adr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      rd_data    <= '0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (start) begin
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            if (supported && !mis_access) begin
              adr_q <= {ea[31:2], 2'b00};
              sel_q <= lane_sel;
              we_q  <= is_store;
              dat_q <= is_store ? lane_wdata : 32'h0;
              // counting from 1 makes the BUS cycle with cnt == limit the last one
              cnt   <= 16'd1;
            end
          end
        end
        LSU_BUS: begin
          cnt <= cnt + 16'd1;
          if (wb.wb_err_i) begin
            bus_error <= 1'b1;
            rd_data   <= '0;
          end else if (wb.wb_ack_i) begin
            if (!we_q) rd_data <= lane_ldata;
          end else if (timeout_hit) begin
            bus_error <= 1'b1;
            rd_data   <= '0;
          end
        end
        LSU_FAULT: begin
          misaligned <= 1'b1;
          rd_data    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != LSU_IDLE);
  assign done        = (state == LSU_DONE);
  assign wb.wb_cyc_o = (state == LSU_BUS);
  assign wb.wb_stb_o = (state == LSU_BUS);
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32I core, directly downstream of the ALU. It consumes the ALU result as the effective address for loads and computes store addresses internally. It runs one Wishbone-classic data-bus transaction per accepted request and returns sign- or zero-extended load data, or a fault, to the writeback/control logic.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of cycles in BUS without `wb_ack_i`/`wb_err_i` before the transaction is aborted as a bus error. Legal range 1..65535.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request strobe, sampled only in IDLE.
- `instruction` input 32: instruction to execute. Must be stable from `start` until `done`.
- `alu_out` input 32: load effective address (rs1 + I-immediate). Must be stable from `start` until `done`.
- `op_a` input 32: rs1 value. Must be stable from `start` until `done`.
- `op_b` input 32: rs2 value (store data). Must be stable from `start` until `done`.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle completion pulse.
- `rd_data` output 32: extended load result, valid when `done` is high.
- `misaligned` output 1: fault flag, qualified by `done`.
- `bus_error` output 1: fault flag, qualified by `done`.
- `wb_cyc_o` output 1: Wishbone cycle.
- `wb_stb_o` output 1: Wishbone strobe.
- `wb_we_o` output 1: Wishbone write enable.
- `wb_adr_o` output 32: word address `{ea[31:2],2'b00}`.
- `wb_sel_o` output 4: byte lane selects.
- `wb_dat_o` output 32: write data.
- `wb_dat_i` input 32: read data.
- `wb_ack_i` input 1: Wishbone acknowledge.
- `wb_err_i` input 1: Wishbone error.

## Operation
- Supported opcodes: OPCODE_LOAD (LB, LH, LW, LBU, LHU) and OPCODE_STORE (SB, SH, SW).
  - Any other opcode or funct3 on `start` produces `done` with both fault flags low and no bus cycle.
- Effective address (ea):
  - Loads: `alu_out`.
  - Stores: `op_a + S_immediate`, 32-bit wrap-around.
- Misalignment checks:
  - Halfword access with `ea[0]=1` is misaligned.
  - Word access with `ea[1:0]!=0` is misaligned.
  - A misaligned access never starts a bus cycle.
- Store lanes, where `lane = ea[1:0]`:
  - SB: `sel = 4'b0001<<lane`, `dat_o = {4{op_b[7:0]}}`.
  - SH: `sel = 4'b0011<<lane`, `dat_o = {2{op_b[15:0]}}`.
  - SW: `sel = 4'b1111`, `dat_o = op_b`.
- Loads:
  - `sel` is set as for the corresponding store width.
  - The selected byte/half of `wb_dat_i` is captured on ack.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `rd_data` holds its last value until the next load completes. It is 0 after any fault.
- State machine:
  - IDLE: on `start`, go to FAULT if the access is misaligned, DONE if the access is unsupported, otherwise BUS. `start` is ignored while `busy`.
  - BUS: `wb_cyc_o = wb_stb_o = 1`. Timeout counter increments each cycle. Exit to DONE on `wb_ack_i`, `wb_err_i`, or count == `TIMEOUT_CYCLES`.
  - FAULT: one cycle; then DONE with `misaligned=1`.
  - DONE: one cycle with `done=1`, then IDLE.
- Priority on BUS exit, highest first:
  - `wb_err_i` → `bus_error=1`.
  - `wb_ack_i` → success.
  - Timeout → `bus_error=1`.
  - So ack arriving on the expiry cycle counts as success, and ack+err together counts as an error.
- Bus outputs (`adr`, `sel`, `we`, `dat_o`) are registered on entry to BUS and held constant throughout BUS.

## Timing
- Reset values: all outputs 0. State IDLE, counter 0.
- Reset mid-transaction drops `wb_cyc_o`/`wb_stb_o` asynchronously, with no `done`.
- `start` in cycle 0 raises `wb_cyc_o`/`wb_stb_o` in cycle 1.
- `wb_ack_i` sampled in cycle N (N≥1) gives `done` in cycle N+1, with `rd_data` and flags registered.
- Minimum bus latency: 2 cycles (ack in cycle 1).
- `wb_cyc_o`/`wb_stb_o` deassert in the cycle after ack/err/timeout.
- Misaligned request: `done` in cycle 2. Unsupported request: `done` in cycle 1.
- Back-to-back: a new `start` is accepted in the cycle after `done`.
- Timeout without any ack/err: `done` in cycle `TIMEOUT_CYCLES+1`.

## Structure
- `params.vh` holds:
  - OPCODE_LOAD and OPCODE_STORE.
  - FUNCT3_LB/LH/LW/LBU/LHU and FUNCT3_SB/SH/SW; add any missing ones.
  - FSM state encodings LSU_IDLE, LSU_BUS, LSU_FAULT, LSU_DONE.
- Instantiate the existing `inst_immediate_decode` for S_immediate.
- One sub-module, `lsu_lane_align`, is natural: combinational `sel`/`dat_o` generation plus load extraction and extension.

## Test plan
- SW: `op_a=0x1000`, S-imm 4, `op_b=0xDEADBEEF`, ack in cycle 1. Required: `adr=0x1004`, `sel=1111`, `we=1`, `dat_o=0xDEADBEEF`; `done` in cycle 2; no fault.
- LB: `alu_out=0x2003`, `wb_dat_i=0x80FF_FF7F` versus LBU on the same data. Required: `sel=1000`; LB `rd_data=0xFFFFFF80`, LBU `rd_data=0x00000080`.
- LH with `alu_out=0x2001`. Required: no `wb_cyc_o` ever; `done` in cycle 2 with `misaligned=1`, `rd_data=0`.
- SH with `ea=0x3002`, `op_b=0x1234ABCD`. Required: `sel=1100`, `dat_o=0xABCDABCD`.
- Stalled slave with `TIMEOUT_CYCLES=4`. Required: `done` with `bus_error=1` in cycle 5. Repeat with ack in cycle 4: success. Repeat with ack+err together: `bus_error=1`.
- Assert `rst_n` low mid-BUS. Required: `wb_cyc_o` low immediately with no `done`. After release: `start` is accepted and `start` pulses while `busy` are ignored.
